seg7_scan_mux: RTL and testbench
================================

SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: digits scanned, legal 1..8.
REQ-002 SHALL have parameter SCAN_DIV, default 5000: clocks per digit slot, legal >= 4.
REQ-003 SHALL have parameter BLANK_CYC, default 2: anti-ghost dark cycles at slot start, legal < SCAN_DIV.
REQ-004 SHALL have ports clk, input, 1, system clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port value, input, 4*NUM_DIGITS, hex nibbles; [3:0] = digit 0, the rightmost.
REQ-007 SHALL have port dp, input, NUM_DIGITS, decimal point per digit.
REQ-008 SHALL have port blank, input, NUM_DIGITS, force digit dark.
REQ-009 SHALL have port bright, input, 4, brightness 0 (off) to 15 (full).
REQ-010 SHALL have port seg, output, 8, segments active-high; [0]=a .. [6]=g, [7]=dp.
REQ-011 SHALL have port dig_n, output, NUM_DIGITS, digit enables active-low.
REQ-012 SHALL have port frame_tick, output, 1, one-cycle pulse at frame start.

Function
REQ-013 SHALL run slot counter 0..SCAN_DIV-1, wrapping; at terminal count digit index advances, NUM_DIGITS-1 wrapping to 0.
REQ-014 SHALL snapshot value, dp, blank into frame registers on the cycle index wraps to 0 and pulse frame_tick that cycle; mid-frame input changes invisible until next frame.
REQ-015 SHALL register seg and dig_n: outputs reflect current index/slot count with exactly 1-cycle latency.
REQ-016 SHALL hold dig_n all-ones and seg zero while slot count < BLANK_CYC.
REQ-017 SHALL run free 4-bit PWM counter; selected digit driven only when pwm < bright or bright == 15; otherwise dig_n all-ones, seg zero.
REQ-018 SHALL decode nibbles 0-F to standard hex glyphs (0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, A..F = A b C d E F); seg[7] = frame dp bit.
REQ-019 SHALL keep digit dark (dig_n bit 1) when its frame blank bit set, dp included.
REQ-020 SHALL assert at most one dig_n bit low in any cycle.

Reset
REQ-021 SHALL on rst clear slot counter, index, PWM counter, frame registers; seg=0, dig_n all-ones, frame_tick=0 next cycle.
REQ-022 SHALL, on rst mid-scan, restart at digit 0 with first frame_tick SCAN_DIV*NUM_DIGITS cycles after rst deasserts.

Configuration
REQ-023 SHALL, with SEG7_LZB_EN defined, blank leading zeros: from highest digit downward, zero nibbles dark until first nonzero nibble or set dp; digit 0 never suppressed.
REQ-024 SHALL, without SEG7_LZB_EN, display all zero nibbles as 0x3F; no LZB logic synthesised.

Structure
REQ-025 SHALL place segment-index constants, glyph table function and SEG_W=8 in shared package seg7_pkg.
REQ-026 SHALL use one combinational sub-module seg7_decode (4-bit nibble + dp -> 8-bit seg).

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, bright=15 unless stated)
REQ-027 SHALL cover reset: rst high 3 cycles mid-scan -> seg=0x00, dig_n=4'b1111, frame_tick=0; digit 0 restarts.
REQ-028 SHALL cover scan: value=16'h1234 -> slot dig_n=1110 seg=0x66, 1101 seg=0x4F, 1011 seg=0x5B, 0111 seg=0x06; frame_tick every 16 cycles.
REQ-029 SHALL cover snapshot: value 16'h1234->16'hABCD mid-frame -> old digits until next frame_tick, then digit 0 seg=0x5E.
REQ-030 SHALL cover PWM: bright=0 -> dig_n always 1111; bright=8 -> driven 8 of every 16 non-guard cycles.
REQ-031 SHALL cover LZB: value=16'h0042, dp=0 -> digits 3,2 dark with SEG7_LZB_EN; seg=0x3F shown without it; dp=4'b1000 -> digit 3 shows 0xBF.
REQ-032 SHALL cover blank: blank=4'b0001 -> dig_n bit 0 never low; other digits unaffected.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment constants and hex glyph table for the 7-segment scanner
package seg7_pkg;

  localparam int SEG_W  = 8;
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef logic [SEG_W-1:0] seg_t;
  typedef logic [3:0]       nibble_t;

  // Bit order is {g,f,e,d,c,b,a}; A..F use the usual A b C d E F shapes.
  function automatic logic [6:0] glyph(input nibble_t nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h3F;
      4'h1:    g = 7'h06;
      4'h2:    g = 7'h5B;
      4'h3:    g = 7'h4F;
      4'h4:    g = 7'h66;
      4'h5:    g = 7'h6D;
      4'h6:    g = 7'h7D;
      4'h7:    g = 7'h07;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h6F;
      4'hA:    g = 7'h77;
      4'hB:    g = 7'h7C;
      4'hC:    g = 7'h39;
      4'hD:    g = 7'h5E;
      4'hE:    g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational hex nibble plus decimal point to segment pattern
module seg7_decode
  import seg7_pkg::*;
(
  input  logic             [3:0] nibble,
  input  logic                   dp,
  output logic [SEG_W-1:0]       seg
);

  always_comb begin
    seg                  = '0;
    seg[SEG_G:SEG_A]     = glyph(nibble);
    seg[SEG_DP]          = dp;
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - multiplexed 7-segment scanner with PWM dimming; SEG7_LZB_EN adds leading-zero blanking
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 5000,
  parameter int BLANK_CYC  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [3:0]              bright,
  output logic [SEG_W-1:0]        seg,
  output logic [NUM_DIGITS-1:0]   dig_n,
  output logic                    frame_tick
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [SLOT_W-1:0]       slot_cnt;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              pwm;
  logic [4*NUM_DIGITS-1:0] frm_value;
  logic [NUM_DIGITS-1:0]   frm_dp;
  logic [NUM_DIGITS-1:0]   frm_blank;

  logic slot_last;
  logic frame_wrap;

  assign slot_last  = (slot_cnt == SLOT_LAST);
  assign frame_wrap = slot_last && (idx == IDX_LAST);

  // Frame registers are only loaded as the scan returns to digit 0, so a
  // frame never mixes old and new input data.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt   <= '0;
      idx        <= '0;
      pwm        <= '0;
      frm_value  <= '0;
      frm_dp     <= '0;
      frm_blank  <= '0;
      frame_tick <= 1'b0;
    end else begin
      pwm        <= pwm + 4'd1;
      frame_tick <= frame_wrap;
      if (slot_last) begin
        slot_cnt <= '0;
        idx      <= frame_wrap ? '0 : idx + IDX_W'(1);
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end
      if (frame_wrap) begin
        frm_value <= value;
        frm_dp    <= dp;
        frm_blank <= blank;
      end
    end
  end

  logic [NUM_DIGITS-1:0] lzb_mask;

`ifdef SEG7_LZB_EN
  logic lzb_run;

  // Walk down from the top digit; suppression stops at the first nonzero
  // nibble or set decimal point. Digit 0 is never part of the walk.
  always_comb begin
    lzb_run  = 1'b1;
    lzb_mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lzb_run     = lzb_run && (frm_value[4*i +: 4] == 4'h0) && !frm_dp[i];
      lzb_mask[i] = lzb_run;
    end
  end
`else
  assign lzb_mask = '0;
`endif

  logic [3:0] cur_nib;
  logic       cur_dp;
  logic       cur_blank;
  logic       cur_lzb;

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_lzb   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = frm_value[4*i +: 4];
        cur_dp    = frm_dp[i];
        cur_blank = frm_blank[i];
        cur_lzb   = lzb_mask[i];
      end
    end
  end

  logic             guard;
  logic             pwm_on;
  logic             lit;
  logic [SEG_W-1:0] dec_seg;

  assign guard  = (int'(slot_cnt) < BLANK_CYC);
  assign pwm_on = (bright == 4'hF) || (pwm < bright);
  assign lit    = !guard && pwm_on && !cur_blank && !cur_lzb;

  seg7_decode u_decode (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .seg    (dec_seg)
  );

  logic [SEG_W-1:0]      seg_d;
  logic [NUM_DIGITS-1:0] dig_n_d;

  // A single index drives the enable, so at most one digit can be low.
  always_comb begin
    seg_d   = lit ? dec_seg : '0;
    dig_n_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lit && (idx == IDX_W'(i))) begin
        dig_n_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg   <= '0;
      dig_n <= '1;
    end else begin
      seg   <= seg_d;
      dig_n <= dig_n_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - scoreboard bench for seg7_scan_mux (4 digits, 4-cycle slots, 1 guard cycle)
module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic [3:0]  bright = 4'hF;
  logic [7:0]  seg;
  logic [3:0]  dig_n;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_tick = -1;
  int onehot_err = 0;
  int dark_err = 0;

  logic [11:0] sb_q[$];
  logic [11:0] exp_e;
  logic        sb_on = 1'b0;

`ifdef SEG7_LZB_EN
  localparam logic [7:0] LZ = 8'h00;
`else
  localparam logic [7:0] LZ = 8'h3F;
`endif

  seg7_scan_mux #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (4),
    .BLANK_CYC  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp         (dp),
    .blank      (blank),
    .bright     (bright),
    .seg        (seg),
    .dig_n      (dig_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Each lit digit occupies SCAN_DIV - BLANK_CYC = 3 output cycles; 8'h00 means dark.
  task automatic push_digit(input int d, input logic [7:0] s);
    logic [3:0] dn;
    if (s != 8'h00) begin
      dn    = 4'hF;
      dn[d] = 1'b0;
      repeat (3) sb_q.push_back({dn, s});
    end
  endtask

  task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    push_digit(0, s0);
    push_digit(1, s1);
    push_digit(2, s2);
    push_digit(3, s3);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!frame_tick && n < 40);
    if (!frame_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no frame_tick in %0d cycles expected one within 16", n);
    end
  endtask

  task automatic count_lit(input int ncyc, output int lit);
    lit = 0;
    repeat (ncyc) begin
      @(posedge clk);
      @(negedge clk);
      if (dig_n != 4'hF) lit++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(~dig_n) > 1) onehot_err++;
      if (dig_n == 4'hF && seg != 8'h00) dark_err++;
    end
    if (sb_on && dig_n != 4'hF) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got dig_n=%b seg=%h expected all digits dark", dig_n, seg);
      end else begin
        exp_e = sb_q.pop_front();
        check("sb_digit", {20'h0, dig_n, seg}, {20'h0, exp_e});
      end
    end
    if (frame_tick) begin
      if (sb_on && last_tick >= 0) check("tick_interval", cyc - last_tick, 16);
      last_tick = cyc;
    end
  end

  initial begin
    int n;
    int lit;
    int d0;
    int other;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_seg", seg, 8'h00);
      check("rst_dig_n", dig_n, 4'hF);
      check("rst_tick", frame_tick, 1'b0);
    end

    rst   = 1'b0;
    value = 16'h1234;
    sb_on = 1'b1;
    push_frame(8'h3F, LZ, LZ, LZ);
    push_frame(8'h66, 8'h4F, 8'h5B, 8'h06);

    wait_tick(n);
    check("first_tick_latency", n, 16);
    repeat (5) @(posedge clk);
    #1 value = 16'hABCD;
    push_frame(8'h5E, 8'h39, 8'h7C, 8'h77);

    wait_tick(n);
    repeat (5) @(posedge clk);
    #1 value = 16'h0042;
    dp = 4'b1000;
    push_frame(8'h5B, 8'h66, 8'h3F, 8'hBF);

    wait_tick(n);
    repeat (5) @(posedge clk);
    #1 dp = 4'b0000;
    push_frame(8'h5B, 8'h66, LZ, LZ);

    wait_tick(n);
    repeat (5) @(posedge clk);
    #1 value = 16'h1234;
    blank = 4'b0001;
    push_frame(8'h00, 8'h4F, 8'h5B, 8'h06);

    wait_tick(n);
    d0    = 0;
    other = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      if (i == 4) #1 blank = 4'b0000;
      @(negedge clk);
      if (!dig_n[0]) d0++;
      if (dig_n[3:1] != 3'b111) other++;
    end
    check("blank_d0_lit", d0, 0);
    check("blank_others_lit", other, 9);

    @(posedge clk);
    #1 sb_on = 1'b0;
    check("sb_drained", sb_q.size(), 0);

    bright = 4'd0;
    repeat (2) @(posedge clk);
    count_lit(32, lit);
    check("pwm_b0", lit, 0);

    bright = 4'd8;
    repeat (2) @(posedge clk);
    count_lit(64, lit);
    check("pwm_b8", lit, 24);

    bright = 4'd4;
    repeat (2) @(posedge clk);
    count_lit(64, lit);
    check("pwm_b4", lit, 12);

    bright = 4'd15;
    repeat (2) @(posedge clk);
    count_lit(64, lit);
    check("pwm_b15", lit, 48);

    check("onehot", onehot_err, 0);
    check("dark_seg", dark_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
